// File: rtl/uart_tx_ctrl_if.sv
// Purpose: request/PISO/serial-line bundle between a byte requester, the PISO and uart_tx_ctrl.
// Latency: wires only; Load_data is combinational from Tx_start inside the controller.
// Backpressure: Tx_busy high means Tx_start is ignored (no queuing); requester must retry.
interface uart_tx_ctrl_if;
    logic       Tx_start;    // transmit request
    logic [7:0] Tx_data_in;  // byte to send, also feeds the PISO parallel input
    logic       piso_data;   // current serial bit presented by the PISO
    logic       Load_data;   // PISO load pulse
    logic       shift;       // PISO shift pulse
    logic       Tx_line;     // serial output, idles high
    logic       Tx_busy;     // frame in progress
    logic       Tx_done;     // one-cycle end-of-frame pulse

    // Requester side (also carries the PISO serial return into the controller).
    modport master (
        output Tx_start,
        output Tx_data_in,
        output piso_data,
        input  Load_data,
        input  shift,
        input  Tx_line,
        input  Tx_busy,
        input  Tx_done
    );

    // Framing controller side.
    modport slave (
        input  Tx_start,
        input  Tx_data_in,
        input  piso_data,
        output Load_data,
        output shift,
        output Tx_line,
        output Tx_busy,
        output Tx_done
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Purpose: UART transmit framing FSM: start, 8 data bits LSB first from the PISO, optional parity, stop.
// Latency: Load_data same cycle as an accepted Tx_start; start bit on the line the cycle after acceptance.
// Backpressure: Tx_start only accepted in IDLE (including the Tx_done cycle); requests while busy are dropped.
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic          clk,
    input  logic          tx_reset,
    uart_tx_ctrl_if.slave tx
);
    // Single-bit-wide counter would be degenerate; CLKS_PER_BIT >= 2 keeps BCW >= 1.
    localparam int              BCW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BCW-1:0]  BCNT_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [BCW-1:0]  BCNT_ONE  = BCW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t         state_q;
    logic [BCW-1:0] bcnt_q;
    logic [2:0]     bidx_q;
    logic           par_q;
    logic           done_q;

    logic           accept_d;
    logic           bit_end_d;
    logic           par_d;
    logic           line_d;

    // Request acceptance, end-of-bit strobe and parity of the incoming byte.
    always_comb begin
        accept_d  = tx_reset && (state_q == S_IDLE) && tx.Tx_start;
        bit_end_d = (bcnt_q == BCNT_LAST);
        par_d     = (PARITY_ODD != 0) ? ~^tx.Tx_data_in : ^tx.Tx_data_in;
    end

    // Serial line is a pure function of registered state plus the PISO bit, so no input glitches reach it.
    always_comb begin
        line_d = 1'b1;
        case (state_q)
            S_IDLE:   line_d = 1'b1;
            S_START:  line_d = 1'b0;
            S_DATA:   line_d = tx.piso_data;
            S_PARITY: line_d = par_q;
            S_STOP:   line_d = 1'b1;
            default:  line_d = 1'b1;
        endcase
    end

    // PISO controls: load only when a request is taken, shift at the last cycle of each data bit.
    // These are mutually exclusive because load needs IDLE and shift needs DATA.
    assign tx.Load_data = accept_d;
    assign tx.shift     = (state_q == S_DATA) && bit_end_d;
    assign tx.Tx_line   = line_d;
    assign tx.Tx_busy   = (state_q != S_IDLE);
    assign tx.Tx_done   = done_q;

    // Framing FSM with baud counter, bit index, latched parity and registered done pulse.
    always_ff @(posedge clk) begin
        if (!tx_reset) begin
            state_q <= S_IDLE;
            bcnt_q  <= '0;
            bidx_q  <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept_d) begin
                        par_q   <= par_d;
                        bcnt_q  <= '0;
                        bidx_q  <= '0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    bcnt_q <= bit_end_d ? '0 : bcnt_q + BCNT_ONE;
                    if (bit_end_d) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    bcnt_q <= bit_end_d ? '0 : bcnt_q + BCNT_ONE;
                    if (bit_end_d) begin
                        bidx_q <= bidx_q + 3'd1;
                        if (bidx_q == 3'd7) begin
                            state_q <= (PARITY_EN != 0) ? S_PARITY : S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    bcnt_q <= bit_end_d ? '0 : bcnt_q + BCNT_ONE;
                    if (bit_end_d) begin
                        state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    bcnt_q <= bit_end_d ? '0 : bcnt_q + BCNT_ONE;
                    if (bit_end_d) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    bcnt_q  <= '0;
                    bidx_q  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Purpose: scoreboard bench for uart_tx_ctrl with three instances (even, odd, no parity) and a PISO model each.
// Latency: expected frames queued at request time; monitors pop on each observed Load_data.
// Backpressure: requester waits for Tx_busy low except in the back-to-back scenario.
module tb_uart_tx_ctrl;
    localparam int C = 4;

    typedef struct packed {
        logic [7:0] d;
        logic       par;
        logic       abort;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] start;
    logic [7:0] data [3];
    logic [2:0] ld, sh, line, busy, done, pd;

    exp_t q0[$], q1[$], q2[$];
    int   n_chk = 0, n_pass = 0;
    int   done_seen [3];
    int   done_exp  [3];
    int   idle_err  [3];
    int   ovl_err = 0;

    always #5 clk = ~clk;

    // Instance 0: even parity, 1: odd parity, 2: no parity. Each has its own PISO model.
    for (genvar g = 0; g < 3; g++) begin : g_dut
        uart_tx_ctrl_if u_if ();
        logic [7:0] sr;

        assign u_if.Tx_start   = start[g];
        assign u_if.Tx_data_in = data[g];
        assign u_if.piso_data  = sr[0];
        assign ld[g]   = u_if.Load_data;
        assign sh[g]   = u_if.shift;
        assign line[g] = u_if.Tx_line;
        assign busy[g] = u_if.Tx_busy;
        assign done[g] = u_if.Tx_done;
        assign pd[g]   = sr[0];

        uart_tx_ctrl #(
            .CLKS_PER_BIT (C),
            .PARITY_EN    ((g != 2) ? 1 : 0),
            .PARITY_ODD   ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk      (clk),
            .tx_reset (rst_n),
            .tx       (u_if)
        );

        always @(posedge clk) begin
            if (u_if.Load_data) sr <= data[g];
            else if (u_if.shift) sr <= {1'b0, sr[7:1]};
        end
    end

    task automatic check(input string name, input int k, input longint act, input longint req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s dut%0d: got %0d, required %0d", name, k, act, req);
    endtask

    task automatic push(input int k, input exp_t e);
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
        if (!e.abort) done_exp[k]++;
    endtask

    task automatic pop(input int k, output exp_t e, output bit ok);
        ok = 1'b1;
        e  = '0;
        case (k)
            0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    // Global pulse counters and Load_data/shift exclusivity.
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done[k] === 1'b1) done_seen[k]++;
            if (ld[k] === 1'b1 && sh[k] === 1'b1) ovl_err++;
        end
    end

    // Monitor: on each accepted request pop the expected frame and check it cycle by cycle.
    task automatic mon(input int k);
        int    p, len, le, se, be, lde;
        bit    ab, ok;
        exp_t  e;
        logic  el, es;
        p   = (k == 2) ? 0 : 1;
        len = (10 + p) * C;
        @(negedge clk);
        forever begin
            if (ld[k] === 1'b1 && rst_n === 1'b1) begin
                pop(k, e, ok);
                if (!ok) begin
                    check("unexpected_frame", k, 1, 0);
                    e.d = data[k]; e.par = 1'b0; e.abort = 1'b0;
                end
                le = 0; se = 0; be = 0; lde = 0; ab = 1'b0;
                for (int c = 0; c < len; c++) begin
                    @(negedge clk);
                    if (c < C)                    el = 1'b0;
                    else if (c < 9 * C)           el = e.d[c / C - 1];
                    else if (p == 1 && c < 10 * C) el = e.par;
                    else                          el = 1'b1;
                    es = (c >= C && c < 9 * C && (c % C) == C - 1) ? 1'b1 : 1'b0;
                    if (line[k] !== el) le++;
                    if (sh[k] !== es) se++;
                    if (busy[k] !== 1'b1 || done[k] !== 1'b0) be++;
                    if (ld[k] !== 1'b0) lde++;
                    if (rst_n !== 1'b1) begin
                        ab = 1'b1;
                        break;
                    end
                end
                check("line_bit_errors", k, le, 0);
                check("shift_errors", k, se, 0);
                check("busy_done_errors", k, be, 0);
                check("load_while_busy", k, lde, 0);
                check("aborted", k, ab, e.abort);
                @(negedge clk);
                if (ab) check("after_reset_line_busy", k, {line[k], busy[k]}, 2'b10);
                else    check("done_cycle_done_busy_line", k, {done[k], busy[k], line[k]}, 3'b101);
            end else begin
                if (busy[k] !== 1'b0 || sh[k] !== 1'b0 || line[k] !== 1'b1) idle_err[k]++;
                if (rst_n !== 1'b1 && ld[k] !== 1'b0) idle_err[k]++;
                @(negedge clk);
            end
        end
    endtask

    initial mon(0);
    initial mon(1);
    initial mon(2);

    // Called at posedge+1; returns with the instance idle in the current cycle.
    task automatic wait_idle(input int k);
        int t = 0;
        while (busy[k] !== 1'b0 && t < 500) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 500) check("idle_timeout", k, 1, 0);
    endtask

    task automatic send(input int k, input logic [7:0] d, input logic par, input bit ab);
        exp_t e;
        wait_idle(k);
        e.d = d; e.par = par; e.abort = ab;
        push(k, e);
        start[k] = 1'b1;
        data[k]  = d;
        @(posedge clk); #1;
        start[k] = 1'b0;
        data[k]  = ~d;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            done_seen[k] = 0; done_exp[k] = 0; idle_err[k] = 0;
            data[k] = 8'hAA;
        end
        rst_n = 1'b0;
        start = 3'b111;
        repeat (2) @(posedge clk);
        #1;
        start = 3'b000;
        rst_n = 1'b1;

        // Single frames; parity values worked by hand.
        send(0, 8'hA5, 1'b0, 1'b0);   // four ones, even -> 0
        send(1, 8'h01, 1'b0, 1'b0);   // one one, odd -> 0
        send(2, 8'hFF, 1'b0, 1'b0);   // no parity slot
        send(0, 8'h01, 1'b1, 1'b0);   // one one, even -> 1
        send(1, 8'hA5, 1'b1, 1'b0);   // four ones, odd -> 1
        send(2, 8'h80, 1'b0, 1'b0);

        // Back-to-back with Tx_start held, data switched mid-frame, extra pulses while busy.
        wait_idle(0);
        e.d = 8'h3C; e.par = 1'b0; e.abort = 1'b0; push(0, e);
        e.d = 8'hC3; e.par = 1'b0; e.abort = 1'b0; push(0, e);
        start[0] = 1'b1;
        data[0]  = 8'h3C;
        repeat (20) @(posedge clk);
        #1;
        data[0] = 8'hC3;
        t = 0;
        while (done[0] !== 1'b1 && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 200) check("b2b_done_timeout", 0, 1, 0);
        @(posedge clk); #1;
        start[0] = 1'b0;
        data[0]  = 8'h00;
        repeat (2) begin
            repeat (10) @(posedge clk);
            #1; start[0] = 1'b1; data[0] = 8'hFF;
            @(posedge clk); #1; start[0] = 1'b0;
        end

        // Reset during data bit 3 of instance 0 (cycles 16..19); others must be idle.
        for (int k = 0; k < 3; k++) wait_idle(k);
        send(0, 8'h96, 1'b0, 1'b1);
        repeat (17) @(posedge clk);
        #1; rst_n = 1'b0;
        @(posedge clk);
        #1; rst_n = 1'b1;
        send(0, 8'h5A, 1'b0, 1'b0);   // four ones, even -> 0
        send(1, 8'h5A, 1'b1, 1'b0);   // four ones, odd -> 1
        send(2, 8'h5A, 1'b0, 1'b0);

        // Drain: all idle with queues consumed, then let monitors finish the done cycle.
        t = 0;
        while ((busy !== 3'b000 || qsize(0) + qsize(1) + qsize(2) != 0) && t < 1000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 1000) check("drain_timeout", 0, 1, 0);
        repeat (4) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("done_pulse_count", k, done_seen[k], done_exp[k]);
            check("idle_or_reset_errors", k, idle_err[k], 0);
            check("frames_not_seen", k, qsize(k), 0);
        end
        check("load_shift_overlap", 0, ovl_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
